// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one variable-latency single-port memory between the CPU
//            fetch and load/store ports. Define ARB_RR_EN for round-robin
//            priority; otherwise data beats fetch on simultaneous requests.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          if_err_q, if_err_d;
  logic          d_err_q, d_err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          grant_data;

  // Winner when sampling in IDLE; only matters when both ports request.
  always_comb begin
`ifdef ARB_RR_EN
    grant_data = (if_req && d_req) ? ~owner_q : d_req;
`else
    grant_data = d_req;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (if_req || d_req) begin
          owner_d    = grant_data;
          mem_req_d  = 1'b1;
          mem_we_d   = grant_data & d_we;
          mem_addr_d = grant_data ? d_addr : if_addr;
          if (grant_data) mem_wdata_d = d_wdata;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          if (owner_q) begin
            if (!mem_we_q) d_rdata_d = mem_rdata;
            d_done_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == C_TO_LAST) begin
          // Abort a hung access: report done with err, leave rdata untouched.
          d_done_d  = owner_q;
          d_err_d   = owner_q;
          if_done_d = ~owner_q;
          if_err_d  = ~owner_q;
          mem_req_d = 1'b0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter (TIMEOUT = 8) with a latency-
//            programmable memory model. Honours ARB_RR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        if_done, if_err, d_done, d_err, mem_req, mem_we, mem_ready, busy, owner;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       r;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_irdata = '0, exp_drdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: ready in the lat-th ACCESS cycle (lat = 0 means never).
  int          lat = 1;
  int          acc_cnt = 0;
  logic [31:0] mem_val = '0;
  logic        ready_m = 1'b0, ready_x = 1'b0;
  assign mem_ready = ready_m | ready_x;

  always @(negedge clk) begin
    if (mem_req) begin
      acc_cnt   = acc_cnt + 1;
      ready_m   = (acc_cnt == lat);
      mem_rdata = ready_m ? mem_val : 32'hDEAD_BEEF;
    end else begin
      acc_cnt   = 0;
      ready_m   = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
    end
  end

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if ((if_err && !if_done) || (d_err && !d_done)) begin
      checks++; errors++;
      $display("FAIL err_without_done: if_err=%b if_done=%b d_err=%b d_done=%b", if_err, if_done, d_err, d_done);
    end
    if (if_done || d_done) begin
      if (if_done && d_done) begin
        checks++; errors++;
        $display("FAIL both_done: if_done=1 d_done=1 expected one");
      end else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: if_done=%b d_done=%b expected none", if_done, d_done);
      end else begin
        r = exp_q.pop_front();
        check("resp_port", {31'b0, d_done}, {31'b0, r.port});
        check("resp_err", {31'b0, d_done ? d_err : if_err}, {31'b0, r.err});
        check("resp_rdata", d_done ? d_rdata : if_rdata, r.rdata);
      end
    end
  end

  logic        hw_we = 1'b0;
  logic [31:0] hw_addr = '0, hw_wdata = '0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for done on a port; counts mem_req cycles and checks that
  // the memory-side outputs stay at hw_* throughout the access.
  task automatic wait_done(input bit port, input int budget,
                           output int cyc, output int mreq, output bit hold_bad);
    cyc = 0; mreq = 0; hold_bad = 1'b0;
    while (!(port ? d_done : if_done) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        mreq++;
        if (mem_we !== hw_we || mem_addr !== hw_addr || (hw_we && mem_wdata !== hw_wdata))
          hold_bad = 1'b1;
      end
    end
    if (!(port ? d_done : if_done)) begin
      checks++; errors++;
      $display("FAIL wait_done: port %0d no done within %0d cycles", port, budget);
    end
  endtask

  function automatic resp_t mk(input bit port, input bit err, input logic [31:0] rd);
    resp_t x;
    x.port = port; x.err = err; x.rdata = rd;
    return x;
  endfunction

  initial begin
    int cyc, mreq;
    bit hb, w, pend;

    // Reset state
    tick(2);
    check("rst_ctrl", {24'b0, mem_req, mem_we, if_done, d_done, if_err, d_err, busy, owner}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rdata", if_rdata | d_rdata, 32'h0);
    reset = 1'b1;
    tick(1);

    // Store, ready after 4 ACCESS cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'h7; lat = 4;
    hw_we = 1'b1; hw_addr = 32'h64; hw_wdata = 32'h7;
    exp_q.push_back(mk(1'b1, 1'b0, exp_drdata));
    wait_done(1'b1, 20, cyc, mreq, hb);
    d_req = 1'b0; d_we = 1'b0;
    check("store_latency", cyc, 5);
    check("store_mreq_cycles", mreq, 4);
    check("store_hold", {31'b0, hb}, 32'h0);
    tick(1);
    check("store_d_rdata", d_rdata, 32'h0);

    // Fetch only, ready in first ACCESS cycle
    if_req = 1'b1; if_addr = 32'h100; lat = 1; mem_val = 32'hE281_1001;
    hw_we = 1'b0; hw_addr = 32'h100;
    exp_irdata = 32'hE281_1001;
    exp_q.push_back(mk(1'b0, 1'b0, exp_irdata));
    wait_done(1'b0, 20, cyc, mreq, hb);
    if_req = 1'b0;
    check("fetch_latency", cyc, 2);
    check("fetch_mreq_cycles", mreq, 1);
    check("fetch_hold", {31'b0, hb}, 32'h0);
    tick(1);
    check("fetch_idle", {30'b0, busy, mem_req}, 32'h0);

    // Simultaneous requests; the winner re-requests during the IDLE gap
    if_addr = 32'h300; d_addr = 32'h200; d_we = 1'b0; lat = 2;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      w = (i % 2 == 0);
`else
      w = 1'b1;
`endif
      if_req = 1'b1; d_req = 1'b1;
      mem_val = 32'hC000_0000 + 32'(i);
      hw_addr = w ? 32'h200 : 32'h300;
      if (w) exp_drdata = mem_val; else exp_irdata = mem_val;
      exp_q.push_back(mk(w, 1'b0, mem_val));
      tick(1);
      check("arb_owner", {31'b0, owner}, {31'b0, w});
      wait_done(w, 20, cyc, mreq, hb);
      check("arb_latency", cyc, 2);
      check("arb_hold", {31'b0, hb}, 32'h0);
      if (w) d_req = 1'b0; else if_req = 1'b0;
      tick(1);
    end
`ifdef ARB_RR_EN
    pend = 1'b1;
`else
    pend = 1'b0;
`endif
    if (pend) d_req = 1'b0; else if_req = 1'b0;
    tick(1);
    if (pend) d_req = 1'b1; else if_req = 1'b1;
    mem_val = 32'hC000_0004;
    hw_addr = pend ? 32'h200 : 32'h300;
    if (pend) exp_drdata = mem_val; else exp_irdata = mem_val;
    exp_q.push_back(mk(pend, 1'b0, mem_val));
    wait_done(pend, 20, cyc, mreq, hb);
    if_req = 1'b0; d_req = 1'b0;
    check("drain_hold", {31'b0, hb}, 32'h0);
    tick(1);

    // Timeout on a data load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; lat = 0;
    hw_addr = 32'h80;
    exp_q.push_back(mk(1'b1, 1'b1, exp_drdata));
    wait_done(1'b1, 30, cyc, mreq, hb);
    d_req = 1'b0;
    check("to_latency", cyc, TO + 1);
    check("to_mreq_cycles", mreq, TO);
    tick(1);
    check("to_after", {30'b0, busy, mem_req}, 32'h0);
    check("to_d_rdata", d_rdata, exp_drdata);

    // Reset in the middle of an ACCESS
    if_req = 1'b1; if_addr = 32'h400; lat = 0;
    tick(2);
    check("mid_busy", {30'b0, busy, mem_req}, 32'h3);
    reset = 1'b0;
    #1;
    check("rst_async", {29'b0, busy, mem_req, owner}, 32'h0);
    check("rst_async_rdata", if_rdata | d_rdata | mem_addr, 32'h0);
    exp_irdata = '0; exp_drdata = '0;
    if_req = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(4);
    if_req = 1'b1; if_addr = 32'h104; lat = 1; mem_val = 32'h1234_5678;
    hw_addr = 32'h104;
    exp_irdata = 32'h1234_5678;
    exp_q.push_back(mk(1'b0, 1'b0, exp_irdata));
    wait_done(1'b0, 20, cyc, mreq, hb);
    if_req = 1'b0;
    check("post_rst_latency", cyc, 2);

    // Stray mem_ready in RESP and in IDLE
    ready_x = 1'b1;
    tick(2);
    ready_x = 1'b0;
    tick(3);
    check("stray_if_rdata", if_rdata, exp_irdata);
    check("stray_d_rdata", d_rdata, exp_drdata);
    check("stray_idle", {30'b0, busy, mem_req}, 32'h0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one variable-latency, single-port unified memory between the CPU instruction-fetch port and the load/store data port.
- Sits between `cpu` (its PC/Instr and ALUResult/WriteData/ReadData/MemWrite paths) and the memory.
- Sequences each access as IDLE→ACCESS→RESP and picks the winner when both ports request.
- Generates per-port done/err pulses, which the CPU uses as stall release, and aborts hung accesses with a timeout.

Parameters:
- AW, 32, address width, both ports and memory side.
- DW, 32, data width.
- TIMEOUT, 255, maximum ACCESS cycles waiting for mem_ready before abort; legal range 1..65535.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  AW  fetch address; stable while if_req.
- if_rdata  out  DW  fetched word; valid in if_done cycle, held until next fetch completes.
- if_done  out  1  one-cycle completion pulse for fetch.
- if_err  out  1  one-cycle pulse coincident with if_done when the fetch timed out.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid in d_done cycle, held until next load completes.
- d_done  out  1  one-cycle completion pulse for data.
- d_err  out  1  timeout flag, coincident with d_done.
- mem_req  out  1  memory access strobe; high throughout ACCESS.
- mem_we  out  1  write enable to memory; 0 for fetches.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; sampled with mem_ready.
- mem_ready  in  1  memory completion; sampled only in ACCESS.
- busy  out  1  high in ACCESS or RESP.
- owner  out  1  current/last grantee: 0 = fetch, 1 = data.

Behaviour:
- Reset (async assert) forces the following, from any state including mid-ACCESS:
  - state IDLE;
  - mem_req, mem_we, if_done, d_done, if_err, d_err, busy = 0;
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0;
  - owner = 0; timeout counter = 0.
  - Any in-flight access is dropped with no done pulse.
- IDLE:
  - If any req is high, register the grantee into owner and capture its addr, we (fetch forces we = 0) and wdata into the mem_* registers.
  - Go to ACCESS; mem_req = 1 from the next cycle. Counter cleared.
- Priority (default): data beats fetch when both requests are high in the same IDLE cycle.
- ACCESS:
  - mem_* outputs are held constant.
  - If mem_ready = 1: capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave d_rdata unchanged). Go to RESP; mem_req drops to 0 the same edge.
  - Else if counter == TIMEOUT-1: go to RESP with err set for the owner; rdata unchanged; mem_req drops.
  - Else counter increments.
  - mem_ready in any other state is ignored.
- RESP: exactly one cycle with the owner's done = 1 (err = 1 if aborted), then IDLE. The non-owner port's done/err stay 0.
- Latency:
  - Minimum request-to-done is 3 cycles: IDLE sample → ACCESS with mem_ready → RESP.
  - Timeout abort gives done TIMEOUT+2 cycles after the request is sampled.
- Back-to-back: the requester drops req the cycle after done. The arbiter always spends at least one IDLE cycle between accesses, so a stale req is never re-granted.
- A req dropped before done is a protocol violation; the access still completes and pulses done.
- busy = (state != IDLE).

Optional Feature:
- ARB_RR_EN defined: round-robin priority on simultaneous requests; the port not in owner wins, so a port cannot win twice in a row while the other waits.
- ARB_RR_EN undefined: fixed data-over-fetch priority as above.
- Single-request behaviour is identical either way.

Test Plan:
1. Fetch only: if_addr = 0x100, memory returns 0xE2811001 with mem_ready in the first ACCESS cycle → mem_req one cycle, mem_we = 0, if_done and if_rdata = 0xE2811001 three cycles after req; d_done stays 0.
2. Store: d_we = 1, d_addr = 0x64, d_wdata = 0x7, mem_ready after 4 ACCESS cycles → mem_we = 1, mem_wdata = 0x7 held all 4 cycles, d_done once, d_rdata unchanged.
3. Simultaneous if_req and d_req, repeated 4 times → default build: data granted every time, fetch served only in gaps; ARB_RR_EN build: grants alternate data, fetch, data, fetch.
4. Timeout: TIMEOUT = 8, mem_ready never asserted on d_req load → d_done and d_err together after 10 cycles, mem_req low afterwards, d_rdata unchanged.
5. Reset mid-ACCESS: drop reset for one cycle during ACCESS → mem_req = 0 immediately (async), no done pulse; a new if_req afterwards completes normally.
6. Late mem_ready: pulse mem_ready in IDLE and in RESP → ignored; no extra done pulses, no rdata change.
